// File: rtl/button_mode_ctrl.sv
// Purpose: synchronize + debounce five push-buttons, emit press pulses, run RUN/SELECT mode FSM.
// Latency: raw edge -> btn_level/btn_pulse after DEBOUNCE_CYCLES+2 edges, FSM outputs one edge later.
// Backpressure: none; inputs are free-running button levels, outputs are registered levels/pulses.
//
// Ports:
//   clk, rst        : system clock, asynchronous active-high reset
//   buttons[4:0]    : raw bouncing inputs ([4] enter, [3] next, [2] prev, [1] cancel, [0] spare)
//   btn_level[4:0]  : debounced levels
//   btn_pulse[4:0]  : one-cycle pulse on each debounced rising edge
//   mode            : committed operating mode
//   pending_mode    : candidate mode while selecting (holds last candidate in RUN)
//   selecting       : FSM is in SELECT
//   mode_changed    : one-cycle pulse on commit
module button_mode_ctrl #(
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int NUM_MODES       = 8,
    localparam int MODE_W         = $clog2(NUM_MODES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        buttons,
    output logic [4:0]        btn_level,
    output logic [4:0]        btn_pulse,
    output logic [MODE_W-1:0] mode,
    output logic [MODE_W-1:0] pending_mode,
    output logic              selecting,
    output logic              mode_changed
);

    localparam int                CNT_W     = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [MODE_W-1:0] MODE_LAST = MODE_W'(NUM_MODES - 1);

    localparam logic [0:0] ST_RUN = 1'b0;
    localparam logic [0:0] ST_SEL = 1'b1;

    logic [4:0]        r_sync1;
    logic [4:0]        r_sync2;
    logic [4:0]        r_level;
    logic [4:0]        r_pulse;
    logic [CNT_W-1:0]  r_cnt [5];
    logic [0:0]        r_state;
    logic [MODE_W-1:0] r_mode;
    logic [MODE_W-1:0] r_pending;
    logic              r_changed;
    logic [MODE_W-1:0] w_inc;
    logic [MODE_W-1:0] w_dec;

    // Two-flop synchronizer for the asynchronous pins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= buttons;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce: a differing synchronized level must persist DEBOUNCE_CYCLES
    // consecutive cycles; any return to the accepted level restarts the count.
    // The press pulse is raised on the same edge the level is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_level <= '0;
            r_pulse <= '0;
            for (int i = 0; i < 5; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 5; i++) begin
                r_pulse[i] <= 1'b0;
                if (r_sync2[i] == r_level[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_MAX) begin
                    r_level[i] <= r_sync2[i];
                    r_pulse[i] <= r_sync2[i];
                    r_cnt[i]   <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_inc = (r_pending == MODE_LAST) ? '0 : r_pending + 1'b1;
    assign w_dec = (r_pending == '0) ? MODE_LAST : r_pending - 1'b1;

    // Mode FSM. In SELECT only one action per cycle:
    // cancel > commit > next > previous.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_RUN;
            r_mode    <= '0;
            r_pending <= '0;
            r_changed <= 1'b0;
        end else begin
            r_changed <= 1'b0;
            if (r_state == ST_RUN) begin
                if (r_pulse[4]) begin
                    r_state   <= ST_SEL;
                    r_pending <= r_mode;
                end
            end else begin
                if (r_pulse[1]) begin
                    r_state <= ST_RUN;
                end else if (r_pulse[4]) begin
                    // Commit always signals, even when the value is unchanged.
                    r_state   <= ST_RUN;
                    r_mode    <= r_pending;
                    r_changed <= 1'b1;
                end else if (r_pulse[3]) begin
                    r_pending <= w_inc;
                end else if (r_pulse[2]) begin
                    r_pending <= w_dec;
                end
            end
        end
    end

    assign btn_level    = r_level;
    assign btn_pulse    = r_pulse;
    assign mode         = r_mode;
    assign pending_mode = r_pending;
    assign selecting    = (r_state == ST_SEL);
    assign mode_changed = r_changed;

endmodule

// File: tb/tb_button_mode_ctrl.sv
// Purpose: directed self-checking bench for button_mode_ctrl (DEBOUNCE_CYCLES=20, NUM_MODES=8).
// Latency: inputs driven and outputs sampled 1 ns after each rising clock edge.
// Backpressure: n/a.
module tb_button_mode_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] buttons;
    logic [4:0] btn_level;
    logic [4:0] btn_pulse;
    logic [2:0] mode;
    logic [2:0] pending_mode;
    logic       selecting;
    logic       mode_changed;

    int vectors = 0;
    int errors  = 0;
    int pcnt [5];
    int mc_cnt;

    button_mode_ctrl #(
        .DEBOUNCE_CYCLES(20),
        .NUM_MODES      (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .buttons     (buttons),
        .btn_level   (btn_level),
        .btn_pulse   (btn_pulse),
        .mode        (mode),
        .pending_mode(pending_mode),
        .selecting   (selecting),
        .mode_changed(mode_changed)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_counts();
        for (int b = 0; b < 5; b++) pcnt[b] = 0;
        mc_cnt = 0;
    endtask

    // Advance n edges, tallying pulses seen on every sampled cycle.
    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            step();
            for (int b = 0; b < 5; b++) pcnt[b] += int'(btn_pulse[b]);
            mc_cnt += int'(mode_changed);
        end
    endtask

    // Clean press held 30 cycles, then clean release for 30 cycles.
    task automatic tap(input logic [4:0] b);
        buttons = b;
        run(30);
        buttons = 5'b0;
        run(30);
    endtask

    initial begin
        rst     = 1'b1;
        buttons = 5'b0;
        clr_counts();
        step();
        step();
        chk("rst_level",    btn_level,    0);
        chk("rst_pulse",    btn_pulse,    0);
        chk("rst_mode",     mode,         0);
        chk("rst_pending",  pending_mode, 0);
        chk("rst_sel",      selecting,    0);
        chk("rst_changed",  mode_changed, 0);
        rst = 1'b0;
        run(3);

        // Press [4] for 50 cycles: level at edge 22, SELECT at 23.
        clr_counts();
        buttons = 5'b10000;
        run(21);
        chk("p4_lvl_e21", btn_level[4], 0);
        run(1);
        chk("p4_lvl_e22", btn_level[4], 1);
        chk("p4_pls_e22", btn_pulse[4], 1);
        chk("p4_sel_e22", selecting,    0);
        run(1);
        chk("p4_pls_e23", btn_pulse[4], 0);
        chk("p4_sel_e23", selecting,    1);
        chk("p4_pend",    pending_mode, 0);
        run(27);
        chk("p4_one_pls", pcnt[4], 1);
        clr_counts();
        buttons = 5'b0;
        run(21);
        chk("rel4_lvl_e21", btn_level[4], 1);
        run(1);
        chk("rel4_lvl_e22", btn_level[4], 0);
        run(10);
        chk("rel4_no_pls", pcnt[4], 0);

        // 15-cycle glitch on [3]: filtered.
        clr_counts();
        buttons = 5'b01000;
        run(15);
        buttons = 5'b0;
        run(30);
        chk("glitch_pls", pcnt[3],      0);
        chk("glitch_lvl", btn_level[3], 0);
        chk("glitch_pend", pending_mode, 0);

        // Bounce 1-0-1 every 5 cycles for 40 cycles, then steady high.
        for (int k = 0; k < 4; k++) begin
            buttons = 5'b01000;
            run(5);
            buttons = 5'b0;
            run(5);
        end
        buttons = 5'b01000;
        run(21);
        chk("bnc_lvl_e21", btn_level[3], 0);
        chk("bnc_no_pls",  pcnt[3],      0);
        run(1);
        chk("bnc_pls_e22", btn_pulse[3], 1);
        run(1);
        chk("bnc_pend_e23", pending_mode, 1);
        run(10);
        chk("bnc_one_pls", pcnt[3], 1);
        buttons = 5'b0;
        run(30);

        // Two more next presses, then commit.
        tap(5'b01000);
        tap(5'b01000);
        chk("inc_pend3", pending_mode, 3);
        chk("inc_sel",   selecting,    1);
        clr_counts();
        tap(5'b10000);
        chk("cmt_mode3",  mode,      3);
        chk("cmt_mc_one", mc_cnt,    1);
        chk("cmt_sel",    selecting, 0);

        // Bring mode back to 0 via three previous presses and a commit.
        tap(5'b10000);
        chk("re_sel_pend", pending_mode, 3);
        tap(5'b00100);
        tap(5'b00100);
        tap(5'b00100);
        chk("dec_pend0", pending_mode, 0);
        tap(5'b10000);
        chk("cmt_mode0", mode, 0);

        // Wrap both directions, then cancel.
        tap(5'b10000);
        chk("wrap_start", pending_mode, 0);
        tap(5'b00100);
        chk("wrap_dec7", pending_mode, 7);
        tap(5'b01000);
        tap(5'b01000);
        chk("wrap_inc1", pending_mode, 1);
        clr_counts();
        tap(5'b00010);
        chk("cancel_sel",  selecting,    0);
        chk("cancel_mode", mode,         0);
        chk("cancel_mc",   mc_cnt,       0);
        chk("cancel_hold", pending_mode, 1);

        // RUN ignores next.
        tap(5'b01000);
        chk("run_ign_sel",  selecting,    0);
        chk("run_ign_pend", pending_mode, 1);

        // Simultaneous cancel + commit at pending=5: cancel wins.
        tap(5'b10000);
        tap(5'b00100);
        tap(5'b00100);
        tap(5'b00100);
        chk("sim_pend5", pending_mode, 5);
        clr_counts();
        tap(5'b10010);
        chk("sim_cc_sel",  selecting, 0);
        chk("sim_cc_mode", mode,      0);
        chk("sim_cc_mc",   mc_cnt,    0);

        // Simultaneous next + previous: increment only.
        tap(5'b10000);
        tap(5'b01100);
        chk("sim_np_pend", pending_mode, 1);
        chk("sim_np_sel",  selecting,    1);

        // Async reset mid-SELECT and mid-debounce with [4] held.
        buttons = 5'b10000;
        run(10);
        rst = 1'b1;
        #1;
        chk("arst_sel",     selecting,    0);
        chk("arst_pend",    pending_mode, 0);
        chk("arst_mode",    mode,         0);
        chk("arst_level",   btn_level,    0);
        chk("arst_pulse",   btn_pulse,    0);
        step();
        rst = 1'b0;
        clr_counts();
        run(21);
        chk("post_lvl_e21", btn_level[4], 0);
        run(1);
        chk("post_pls_e22", btn_pulse[4], 1);
        run(1);
        chk("post_sel_e23", selecting,    1);
        chk("post_pend",    pending_mode, 0);
        buttons = 5'b0;
        run(30);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
